gam_learning_sequencer: RTL and testbench

- Stores the training patterns for the GAM Memory_Layer, organised per class.
- On start, presents every stored node vector with its class index to the memory layer over a valid/ready handshake, class 1 first, node 1 first.
- After the last transfer, raises learning_done and switches learning_recall to RECALL.
- Replaces the hand-coded pattern feeding in the benches and is the block that runs the memory layer's learning phase.

---
 rtl/gam_learning_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_gam_learning_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gam_learning_sequencer.sv
// Pattern store and learning-phase driver for the GAM memory layer: holds node
// vectors per class and streams them out class-major over a valid/ready link.
module gam_learning_sequencer #(
    parameter int NODE_W      = 32,
    parameter int CLASS_COUNT = 4,
    parameter int NODE_COUNT  = 16,
    parameter int CW          = $clog2(CLASS_COUNT + 1),
    parameter int NW          = $clog2(NODE_COUNT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CW-1:0]     wr_class,
    input  logic [NODE_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    input  logic              clear,
    input  logic              start,
    output logic              busy,
    output logic [NODE_W-1:0] ml_x,
    output logic [31:0]       ml_c,
    output logic              ml_valid,
    input  logic              ml_ready,
    output logic              learning_done,
    output logic              learning_recall,
    output logic [NW+CW-1:0]  node_total
);

    localparam int CIW = (CLASS_COUNT > 1) ? $clog2(CLASS_COUNT) : 1;
    localparam int NIW = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        ISSUE  = 2'd2,
        RECALL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cls_q, cls_d;
    logic [NW-1:0]       node_q, node_d;
    logic [NODE_W-1:0]   ml_x_q, ml_x_d;
    logic                ml_valid_q, ml_valid_d;
    logic                done_q, done_d;
    logic [NW+CW-1:0]    total_q, total_d;
    logic                wr_ack_q, wr_ack_d;
    logic                wr_err_q, wr_err_d;
    logic [NW-1:0]       cnt_q [CLASS_COUNT];
    logic [NW-1:0]       cnt_d [CLASS_COUNT];
    logic [NODE_W-1:0]   mem_q [CLASS_COUNT][NODE_COUNT];

    logic                busy_s;
    logic                class_ok_s;
    logic                mem_we_s;
    logic [CIW-1:0]      wr_idx_s;
    logic [CIW-1:0]      cls_idx_s;
    logic [NW-1:0]       cur_cnt_s;

    // Classes and nodes are 1-based externally; the arrays are 0-based.
    assign busy_s     = (state_q == SCAN) || (state_q == ISSUE);
    assign class_ok_s = (wr_class != {CW{1'b0}}) && (wr_class <= CW'(CLASS_COUNT));
    assign wr_idx_s   = CIW'(wr_class - CW'(1));
    assign cls_idx_s  = CIW'(cls_q - CW'(1));
    assign cur_cnt_s  = cnt_q[cls_idx_s];

    // Next-state, handshake and write-acceptance logic.
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        node_d     = node_q;
        ml_x_d     = ml_x_q;
        ml_valid_d = ml_valid_q;
        done_d     = done_q;
        total_d    = total_q;
        cnt_d      = cnt_q;
        mem_we_s   = 1'b0;

        if (wr_en && !busy_s && !clear && class_ok_s &&
            (cnt_q[wr_idx_s] < NW'(NODE_COUNT)) && (wr_data != {NODE_W{1'b0}})) begin
            mem_we_s          = 1'b1;
            cnt_d[wr_idx_s]   = cnt_q[wr_idx_s] + NW'(1);
        end else begin
            mem_we_s = 1'b0;
        end
        wr_ack_d = mem_we_s;
        wr_err_d = wr_en && !mem_we_s;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    cls_d   = CW'(1);
                    total_d = {(NW+CW){1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (cur_cnt_s != {NW{1'b0}}) begin
                    state_d    = ISSUE;
                    node_d     = NW'(1);
                    ml_x_d     = mem_q[cls_idx_s][0];
                    ml_valid_d = 1'b1;
                end else if (cls_q == CW'(CLASS_COUNT)) begin
                    state_d = RECALL;
                    done_d  = 1'b1;
                end else begin
                    cls_d = cls_q + CW'(1);
                end
            end
            ISSUE: begin
                if (ml_valid_q && ml_ready) begin
                    total_d = total_q + (NW+CW)'(1);
                    if (node_q < cur_cnt_s) begin
                        // node_q is 1-based, so it already indexes the next entry.
                        node_d = node_q + NW'(1);
                        ml_x_d = mem_q[cls_idx_s][NIW'(node_q)];
                    end else if (cls_q < CW'(CLASS_COUNT)) begin
                        ml_valid_d = 1'b0;
                        cls_d      = cls_q + CW'(1);
                        state_d    = SCAN;
                    end else begin
                        ml_valid_d = 1'b0;
                        state_d    = RECALL;
                        done_d     = 1'b1;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            RECALL: begin
                if (start) begin
                    state_d = SCAN;
                    cls_d   = CW'(1);
                    total_d = {(NW+CW){1'b0}};
                    done_d  = 1'b0;
                end else begin
                    state_d = RECALL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            state_d    = IDLE;
            cls_d      = {CW{1'b0}};
            node_d     = {NW{1'b0}};
            ml_valid_d = 1'b0;
            done_d     = 1'b0;
            total_d    = {(NW+CW){1'b0}};
            for (int i = 0; i < CLASS_COUNT; i++) begin
                cnt_d[i] = {NW{1'b0}};
            end
        end else begin
            state_d = state_d;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cls_q      <= {CW{1'b0}};
            node_q     <= {NW{1'b0}};
            ml_x_q     <= {NODE_W{1'b0}};
            ml_valid_q <= 1'b0;
            done_q     <= 1'b0;
            total_q    <= {(NW+CW){1'b0}};
            wr_ack_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            for (int i = 0; i < CLASS_COUNT; i++) begin
                cnt_q[i] <= {NW{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            node_q     <= node_d;
            ml_x_q     <= ml_x_d;
            ml_valid_q <= ml_valid_d;
            done_q     <= done_d;
            total_q    <= total_d;
            wr_ack_q   <= wr_ack_d;
            wr_err_q   <= wr_err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Pattern storage; contents are meaningless beyond each class count.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_idx_s][NIW'(cnt_q[wr_idx_s])] <= wr_data;
        end
    end

    assign busy            = busy_s;
    assign ml_x            = ml_x_q;
    assign ml_c            = 32'(cls_q);
    assign ml_valid        = ml_valid_q;
    assign learning_done   = done_q;
    assign learning_recall = done_q;
    assign node_total      = total_q;
    assign wr_ack          = wr_ack_q;
    assign wr_err          = wr_err_q;

endmodule

// File: tb/tb_gam_learning_sequencer.sv
// Directed bench for gam_learning_sequencer: loads patterns, runs learning
// passes under various ready patterns and compares against hand-derived values.
module tb_gam_learning_sequencer;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_class;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        wr_err;
    logic        clear;
    logic        start;
    logic        busy;
    logic [31:0] ml_x;
    logic [31:0] ml_c;
    logic        ml_valid;
    logic        ml_ready;
    logic        learning_done;
    logic        learning_recall;
    logic [7:0]  node_total;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_x[$];
    int          exp_c[$];
    logic [31:0] hs_x[$];
    int          hs_c[$];
    int          done_cyc;
    int          first_valid;
    int          scan_cyc;
    int          hold_cyc;

    logic [31:0] set1 [8] = '{32'h3, 32'h400, 32'h70005, 32'h101,
                              32'hc0b0a09, 32'h604, 32'h60002, 32'h202};

    gam_learning_sequencer dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_class(wr_class),
        .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err), .clear(clear),
        .start(start), .busy(busy), .ml_x(ml_x), .ml_c(ml_c),
        .ml_valid(ml_valid), .ml_ready(ml_ready), .learning_done(learning_done),
        .learning_recall(learning_recall), .node_total(node_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] c, input logic [31:0] d, input logic exp_ack, input string tag);
        wr_en = 1'b1; wr_class = c; wr_data = d;
        tick();
        wr_en = 1'b0;
        chk({tag, "_ack"}, 64'(wr_ack), 64'(exp_ack));
        chk({tag, "_err"}, 64'(wr_err), 64'(!exp_ack));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Start a pass (optionally with a write in the same cycle) and collect handshakes.
    task automatic run_pass(input int stall_idx, input int stall_len, input logic [31:0] hold_x,
                            input logic co_wr, input logic [2:0] co_cls, input logic [31:0] co_data);
        int cyc = 1;
        int hs = 0;
        int stalled = 0;
        hs_x.delete(); hs_c.delete();
        first_valid = 0; scan_cyc = 0; hold_cyc = 0;
        start = 1'b1; wr_en = co_wr; wr_class = co_cls; wr_data = co_data;
        tick();
        start = 1'b0; wr_en = 1'b0;
        if (co_wr) chk("co_write_ack", 64'(wr_ack), 64'd1);
        chk("pass_busy_c1", 64'(busy), 64'd1);
        chk("pass_recall_c1", 64'(learning_recall), 64'd0);
        while (!learning_done && cyc < 200) begin
            if (ml_valid && hs == stall_idx && stalled < stall_len) begin
                ml_ready = 1'b0;
                stalled++;
                if (ml_x == hold_x) hold_cyc++;
            end else begin
                ml_ready = 1'b1;
            end
            if (busy && !ml_valid) scan_cyc++;
            if (ml_valid && first_valid == 0) first_valid = cyc;
            if (ml_valid && ml_ready) begin
                hs_x.push_back(ml_x);
                hs_c.push_back(int'(ml_c));
                hs++;
            end
            tick();
            cyc++;
        end
        ml_ready = 1'b1;
        chk("pass_bounded", 64'(cyc < 200), 64'd1);
        done_cyc = cyc;
    endtask

    task automatic check_pass(input string tag, input int e_done, input int e_first, input int e_total);
        chk({tag, "_hs_count"}, 64'(hs_x.size()), 64'(exp_x.size()));
        for (int i = 0; i < exp_x.size() && i < hs_x.size(); i++) begin
            chk($sformatf("%s_x%0d", tag, i), 64'(hs_x[i]), 64'(exp_x[i]));
            chk($sformatf("%s_c%0d", tag, i), 64'(hs_c[i]), 64'(exp_c[i]));
        end
        chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(e_done));
        chk({tag, "_first_valid"}, 64'(first_valid), 64'(e_first));
        chk({tag, "_scan_cyc"}, 64'(scan_cyc), 64'd4);
        chk({tag, "_node_total"}, 64'(node_total), 64'(e_total));
        chk({tag, "_recall"}, 64'(learning_recall), 64'd1);
        chk({tag, "_valid_low"}, 64'(ml_valid), 64'd0);
    endtask

    initial begin
        int guard;
        reset = 1'b1; wr_en = 1'b0; wr_class = 3'd0; wr_data = 32'd0;
        clear = 1'b0; start = 1'b0; ml_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", 64'(ml_valid), 64'd0);
        chk("rst_done", 64'(learning_done), 64'd0);
        chk("rst_recall", 64'(learning_recall), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_total", 64'(node_total), 64'd0);
        chk("rst_ml_x", 64'(ml_x), 64'd0);
        chk("rst_ml_c", 64'(ml_c), 64'd0);
        chk("rst_ack", 64'(wr_ack), 64'd0);
        reset = 1'b0;
        tick();

        // Class-1 transfer: empty classes 2..4 each take one scan cycle.
        for (int i = 0; i < 8; i++) wr(3'd1, set1[i], 1'b1, "t1_wr");
        exp_x.delete(); exp_c.delete();
        for (int i = 0; i < 8; i++) begin exp_x.push_back(set1[i]); exp_c.push_back(1); end
        run_pass(-1, 0, 32'd0, 1'b0, 3'd0, 32'd0);
        check_pass("t1", 13, 2, 8);

        // Backpressure on the 4th vector, re-learn started from RECALL.
        run_pass(3, 3, 32'h101, 1'b0, 3'd0, 32'd0);
        check_pass("t2", 16, 2, 8);
        chk("t2_hold_cycles", 64'(hold_cyc), 64'd3);

        // Empty-class skip; last write shares the start cycle.
        do_clear();
        chk("clr_done", 64'(learning_done), 64'd0);
        chk("clr_total", 64'(node_total), 64'd0);
        wr(3'd1, 32'h11, 1'b1, "t3_wr");
        wr(3'd1, 32'h12, 1'b1, "t3_wr");
        wr(3'd3, 32'h31, 1'b1, "t3_wr");
        exp_x = '{32'h11, 32'h12, 32'h31, 32'h32};
        exp_c = '{1, 1, 3, 3};
        run_pass(-1, 0, 32'd0, 1'b1, 3'd3, 32'h32);
        check_pass("t3", 9, 2, 4);

        // Write rejection: overflow, zero data, class 0.
        do_clear();
        exp_x.delete(); exp_c.delete();
        for (int i = 0; i < 16; i++) begin
            wr(3'd2, 32'h200 + 32'(i + 1), 1'b1, "t4_wr");
            exp_x.push_back(32'h200 + 32'(i + 1));
            exp_c.push_back(2);
        end
        wr(3'd2, 32'h2ff, 1'b0, "t4_full");
        wr(3'd2, 32'h0, 1'b0, "t4_zero");
        wr(3'd0, 32'h5, 1'b0, "t4_cls0");
        run_pass(-1, 0, 32'd0, 1'b0, 3'd0, 32'd0);
        check_pass("t4", 21, 3, 16);

        // Write attempted while ISSUE is holding under backpressure.
        ml_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("t4_issue_valid", 64'(ml_valid), 64'd1);
        chk("t4_issue_x", 64'(ml_x), 64'h201);
        wr(3'd1, 32'h5, 1'b0, "t4_busy_wr");
        chk("t4_issue_hold_x", 64'(ml_x), 64'h201);
        ml_ready = 1'b1;
        guard = 0;
        while (!learning_done && guard < 100) begin tick(); guard++; end
        chk("t4_issue_bounded", 64'(guard < 100), 64'd1);
        chk("t4_issue_total", 64'(node_total), 64'd16);

        // Nothing stored.
        do_clear();
        exp_x.delete(); exp_c.delete();
        run_pass(-1, 0, 32'd0, 1'b0, 3'd0, 32'd0);
        check_pass("t5", 5, 0, 0);

        // Reset after 3 handshakes aborts the pass and drops the counts.
        do_clear();
        for (int i = 0; i < 8; i++) wr(3'd1, set1[i], 1'b1, "t6_wr");
        ml_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_pre_total", 64'(node_total), 64'd3);
        chk("t6_pre_x", 64'(ml_x), 64'h101);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_rst_valid", 64'(ml_valid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_total", 64'(node_total), 64'd0);
        run_pass(-1, 0, 32'd0, 1'b0, 3'd0, 32'd0);
        check_pass("t6", 5, 0, 0);

        // clear wins over start in RECALL.
        clear = 1'b1; start = 1'b1; tick();
        clear = 1'b0; start = 1'b0;
        chk("t6_cs_done", 64'(learning_done), 64'd0);
        chk("t6_cs_recall", 64'(learning_recall), 64'd0);
        chk("t6_cs_busy", 64'(busy), 64'd0);
        tick();
        chk("t6_cs_idle", 64'(busy), 64'd0);
        chk("t6_cs_valid", 64'(ml_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
